// File: rtl/transpose_pkg.sv
// transpose_pkg: FSM states and size helpers for the chunked transpose sequencer.
// Ports: none (package).
package transpose_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_RD_WAIT,
    S_WR,
    S_FIN
  } state_t;

  function automatic int log2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

  // Width of a counter indexing v items; never zero.
  function automatic int wid(input int v);
    return (log2(v) > 0) ? log2(v) : 1;
  endfunction

  function automatic int row_inc(input int dw, input int as);
    return dw * as / 8;
  endfunction

  function automatic int chunk_bytes(input int dw, input int cs);
    return dw * cs / 8;
  endfunction

  function automatic int nch(input int as, input int cs);
    return as / cs;
  endfunction

endpackage

// File: rtl/chunk_addr_gen.sv
// chunk_addr_gen: combinational source/destination row byte address.
// Ports: base, ci, cj, r, transpose in; src_addr, dst_addr out.
module chunk_addr_gen
  import transpose_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int ARR_SIZE   = 8,
  parameter int ADDR_WIDTH = 64,
  parameter int CHUNK_SIZE = 4
) (
  input  logic [ADDR_WIDTH-1:0] base,
  input  logic [wid(nch(ARR_SIZE, CHUNK_SIZE))-1:0] ci,
  input  logic [wid(nch(ARR_SIZE, CHUNK_SIZE))-1:0] cj,
  input  logic [wid(CHUNK_SIZE)-1:0] r,
  input  logic transpose,
  output logic [ADDR_WIDTH-1:0] src_addr,
  output logic [ADDR_WIDTH-1:0] dst_addr
);

  localparam int RS  = log2(row_inc(DATA_WIDTH, ARR_SIZE));
  localparam int CBS = log2(chunk_bytes(DATA_WIDTH, CHUNK_SIZE));
  localparam int CRS = log2(CHUNK_SIZE) + RS;

  logic [ADDR_WIDTH-1:0] off_r;
  logic [ADDR_WIDTH-1:0] di;
  logic [ADDR_WIDTH-1:0] dj;

  always_comb begin
    off_r = ADDR_WIDTH'(r) << RS;
    di = transpose ? ADDR_WIDTH'(cj) : ADDR_WIDTH'(ci);
    dj = transpose ? ADDR_WIDTH'(ci) : ADDR_WIDTH'(cj);
    src_addr = base
             + (ADDR_WIDTH'(ci) << CRS)
             + (ADDR_WIDTH'(cj) << CBS)
             + off_r;
    dst_addr = base
             + (di << CRS)
             + (dj << CBS)
             + off_r;
  end

endmodule

// File: rtl/transpose_chunk_sched.sv
// transpose_chunk_sched: walks chunks, issues row reads then row writes per chunk.
// Ports: start/transpose/base_addr, busy/done, rd_*/wr_* request ports, row_idx; perf_* with TRANSPOSE_SCHED_PERF_EN.
module transpose_chunk_sched
  import transpose_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int ARR_SIZE   = 8,
  parameter int ADDR_WIDTH = 64,
  parameter int CHUNK_SIZE = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic transpose,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  output logic busy,
  output logic done,
  output logic rd_valid,
  input  logic rd_ready,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic rd_data_valid,
  output logic wr_valid,
  input  logic wr_ready,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [wid(CHUNK_SIZE)-1:0] row_idx
`ifdef TRANSPOSE_SCHED_PERF_EN
  ,
  output logic [31:0] perf_cycles,
  output logic [31:0] perf_stalls
`endif
);

  localparam int NCH = nch(ARR_SIZE, CHUNK_SIZE);
  localparam int CW  = wid(NCH);
  localparam int RW  = wid(CHUNK_SIZE);
  localparam int NW  = log2(CHUNK_SIZE) + 1;
  localparam logic [CW-1:0] CLAST = CW'(NCH - 1);
  localparam logic [RW-1:0] RLAST = RW'(CHUNK_SIZE - 1);
  localparam logic [NW-1:0] NFULL = NW'(CHUNK_SIZE);

  state_t state, state_n;
  logic [CW-1:0] ci, ci_n, cj, cj_n;
  logic [RW-1:0] row_n;
  logic [NW-1:0] ret, ret_n;
  logic [ADDR_WIDTH-1:0] base_q, base_n;
  logic tr_q, tr_n;
  logic busy_n, done_n, rd_valid_n, wr_valid_n;
  logic [ADDR_WIDTH-1:0] rd_addr_n, wr_addr_n;
  logic [ADDR_WIDTH-1:0] src, dst;
  logic ld_rd, ld_wr, ret_inc, ret_full;
  logic rd_hs, wr_hs;

  // Addresses are formed from next-cycle indices so they register alongside valid.
  chunk_addr_gen #(
    .DATA_WIDTH(DATA_WIDTH),
    .ARR_SIZE  (ARR_SIZE),
    .ADDR_WIDTH(ADDR_WIDTH),
    .CHUNK_SIZE(CHUNK_SIZE)
  ) u_addr (
    .base     (base_n),
    .ci       (ci_n),
    .cj       (cj_n),
    .r        (row_n),
    .transpose(tr_n),
    .src_addr (src),
    .dst_addr (dst)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      ci       <= '0;
      cj       <= '0;
      row_idx  <= '0;
      ret      <= '0;
      base_q   <= '0;
      tr_q     <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      rd_valid <= 1'b0;
      wr_valid <= 1'b0;
      rd_addr  <= '0;
      wr_addr  <= '0;
    end else begin
      state    <= state_n;
      ci       <= ci_n;
      cj       <= cj_n;
      row_idx  <= row_n;
      ret      <= ret_n;
      base_q   <= base_n;
      tr_q     <= tr_n;
      busy     <= busy_n;
      done     <= done_n;
      rd_valid <= rd_valid_n;
      wr_valid <= wr_valid_n;
      rd_addr  <= rd_addr_n;
      wr_addr  <= wr_addr_n;
    end
  end

  always_comb begin
    state_n    = state;
    ci_n       = ci;
    cj_n       = cj;
    row_n      = row_idx;
    base_n     = base_q;
    tr_n       = tr_q;
    busy_n     = busy;
    done_n     = 1'b0;
    rd_valid_n = rd_valid;
    wr_valid_n = wr_valid;
    ld_rd      = 1'b0;
    ld_wr      = 1'b0;
    rd_hs      = rd_valid && rd_ready;
    wr_hs      = wr_valid && wr_ready;
    // Returns beyond a full chunk are spurious and dropped.
    ret_inc    = rd_data_valid && (state != S_IDLE)
              && (state != S_FIN) && (ret != NFULL);
    ret_n      = ret + NW'(ret_inc);
    ret_full   = (ret_n == NFULL);

    unique case (state)
      S_IDLE: begin
        if (start) begin
          state_n    = S_RD;
          base_n     = base_addr;
          tr_n       = transpose;
          ci_n       = '0;
          cj_n       = '0;
          row_n      = '0;
          ret_n      = '0;
          busy_n     = 1'b1;
          rd_valid_n = 1'b1;
          ld_rd      = 1'b1;
        end
      end
      S_RD: begin
        if (rd_hs) begin
          if (row_idx == RLAST) begin
            row_n      = '0;
            rd_valid_n = 1'b0;
            if (ret_full) begin
              state_n    = S_WR;
              wr_valid_n = 1'b1;
              ld_wr      = 1'b1;
            end else begin
              state_n = S_RD_WAIT;
            end
          end else begin
            row_n = row_idx + 1'b1;
            ld_rd = 1'b1;
          end
        end
      end
      S_RD_WAIT: begin
        if (ret_full) begin
          state_n    = S_WR;
          wr_valid_n = 1'b1;
          ld_wr      = 1'b1;
        end
      end
      S_WR: begin
        if (wr_hs) begin
          if (row_idx == RLAST) begin
            row_n      = '0;
            ret_n      = '0;
            wr_valid_n = 1'b0;
            if (ci == CLAST && cj == CLAST) begin
              state_n = S_FIN;
              busy_n  = 1'b0;
              done_n  = 1'b1;
            end else begin
              state_n    = S_RD;
              rd_valid_n = 1'b1;
              ld_rd      = 1'b1;
              if (cj == CLAST) begin
                cj_n = '0;
                ci_n = ci + 1'b1;
              end else begin
                cj_n = cj + 1'b1;
              end
            end
          end else begin
            row_n = row_idx + 1'b1;
            ld_wr = 1'b1;
          end
        end
      end
      S_FIN: state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase

    rd_addr_n = ld_rd ? src : rd_addr;
    wr_addr_n = ld_wr ? dst : wr_addr;
  end

`ifdef TRANSPOSE_SCHED_PERF_EN
  logic stall;
  assign stall = (rd_valid && !rd_ready)
              || (wr_valid && !wr_ready);

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_cycles <= '0;
      perf_stalls <= '0;
    end else if (state == S_IDLE && start) begin
      perf_cycles <= '0;
      perf_stalls <= '0;
    end else begin
      if (busy && perf_cycles != '1)
        perf_cycles <= perf_cycles + 1'b1;
      if (stall && perf_stalls != '1)
        perf_stalls <= perf_stalls + 1'b1;
    end
  end
`endif

endmodule
